// File: rtl/dds_cfg_ctrl.sv
// dds_cfg_ctrl - SPI-fed configuration controller for an FSK DDS.
//
// Parses 7-byte frames {A5, CMD, B0, B1, B2, B3, CHK} that arrive as
// rx_valid/rx_data byte strobes. CHK is the XOR of CMD and the four data
// bytes. CMD 01 loads shadow_f0, CMD 02 loads shadow_f1, and CMD 03 arms a
// commit. An armed commit copies both shadows into the active registers on
// the next accumulator wrap. The key input is also sampled on wraps only, so
// frequency switching stays phase-continuous.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_valid   one-cycle strobe, rx_data holds a received byte
//   rx_data    received byte
//   key        FSK select (0 = F0, 1 = F1)
//   acc_wrap   one-cycle strobe on phase-accumulator wrap
//   fword      frequency word to the DDS (registered)
//   fword_upd  one-cycle pulse in the first cycle fword shows a new value
//   tx_data    status {commit_pending, last_frame_ok, busy, err_cnt[4:0]}
//   busy       a frame is in progress
//   err_cnt    saturating count of rejected frames
module dds_cfg_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        key,
  input  logic        acc_wrap,
  output logic [31:0] fword,
  output logic        fword_upd,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // The counter value at which this idle cycle is the TIMEOUT_CYC-th one.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_D0   = 3'd2,
    S_D1   = 3'd3,
    S_D2   = 3'd4,
    S_D3   = 3'd5,
    S_CHK  = 3'd6
  } state_t;

  // The frame checksum is the XOR of the command byte and the four data bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [31:0] d);
    frame_chk = cmd ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   sh0_q, sh0_d, sh1_q, sh1_d;
  logic [31:0]   act0_q, act0_d, act1_q, act1_d;
  logic          key_q, key_d;
  logic          pend_q, pend_d;
  logic          lfo_q, lfo_d;
  logic [7:0]    err_q, err_d;
  logic [31:0]   fword_q, fword_d;
  logic          upd_q, upd_d;
  logic          busy_q, busy_d;
  logic [7:0]    tx_q, tx_d;
  logic          frame_ok_s, frame_bad_s, commit_s;

  // Next-state logic: parser, timeout, frame actions, commit and key sampling.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    act0_d      = act0_q;
    act1_d      = act1_q;
    key_d       = key_q;
    pend_d      = pend_q;
    lfo_d       = lfo_q;
    err_d       = err_q;
    frame_ok_s  = 1'b0;
    frame_bad_s = 1'b0;
    commit_s    = 1'b0;

    if (state_q == S_IDLE) begin
      tcnt_d = '0;
      if (rx_valid && (rx_data == SYNC)) begin
        state_d = S_CMD;
      end else begin
        state_d = S_IDLE;
      end
    end else if (rx_valid) begin
      // An accepted byte wins over a timeout that expires in the same cycle.
      tcnt_d = '0;
      case (state_q)
        S_CMD: begin cmd_d = rx_data;          state_d = S_D0;  end
        S_D0:  begin data_d[7:0]   = rx_data;  state_d = S_D1;  end
        S_D1:  begin data_d[15:8]  = rx_data;  state_d = S_D2;  end
        S_D2:  begin data_d[23:16] = rx_data;  state_d = S_D3;  end
        S_D3:  begin data_d[31:24] = rx_data;  state_d = S_CHK; end
        S_CHK: begin
          state_d = S_IDLE;
          if ((rx_data == frame_chk(cmd_q, data_q)) &&
              (cmd_q >= 8'h01) && (cmd_q <= 8'h03)) begin
            frame_ok_s = 1'b1;
          end else begin
            frame_bad_s = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tcnt_q == TMO_LAST) begin
      state_d     = S_IDLE;
      tcnt_d      = '0;
      frame_bad_s = 1'b1;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end

    if (frame_ok_s) begin
      lfo_d = 1'b1;
      case (cmd_q)
        8'h01:   sh0_d = data_q;
        8'h02:   sh1_d = data_q;
        8'h03:   commit_s = 1'b1;
        default: lfo_d = 1'b1;
      endcase
    end else if (frame_bad_s) begin
      lfo_d = 1'b0;
      if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end else begin
        err_d = err_q;
      end
    end else begin
      lfo_d = lfo_q;
    end

    // The transfer uses the shadows as they stood before this edge. A commit
    // that completes on the same edge re-arms pending for the next wrap.
    if (acc_wrap) begin
      key_d = key;
      if (pend_q) begin
        act0_d = sh0_q;
        act1_d = sh1_q;
        pend_d = 1'b0;
      end else begin
        pend_d = pend_q;
      end
    end else begin
      key_d = key_q;
    end
    if (commit_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end

    fword_d = key_q ? act1_q : act0_q;
    upd_d   = (fword_d != fword_q);
    busy_d  = (state_d != S_IDLE);
    tx_d    = {pend_d, lfo_d, busy_d, err_d[4:0]};
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      cmd_q   <= 8'h00;
      data_q  <= 32'h0;
      sh0_q   <= 32'h0;
      sh1_q   <= 32'h0;
      act0_q  <= 32'h0;
      act1_q  <= 32'h0;
      key_q   <= 1'b0;
      pend_q  <= 1'b0;
      lfo_q   <= 1'b0;
      err_q   <= 8'h00;
      fword_q <= 32'h0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      tx_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      act0_q  <= act0_d;
      act1_q  <= act1_d;
      key_q   <= key_d;
      pend_q  <= pend_d;
      lfo_q   <= lfo_d;
      err_q   <= err_d;
      fword_q <= fword_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

  assign fword     = fword_q;
  assign fword_upd = upd_q;
  assign tx_data   = tx_q;
  assign busy      = busy_q;
  assign err_cnt   = err_q;

endmodule
